// File: rtl/timestamped_token_driver.sv
// Timestamped token driver.
// Accepts (time, value) tokens into a small FIFO and keeps a local time
// counter. When local time reaches the stamp of the oldest buffered token, the
// token's value is registered onto q and the token is popped. A token that is
// found already in the past is still applied, one per cycle, and leaves the
// sticky late_err flag set.
//
// Handshake: a token moves from the producer into the buffer on a rising clock
// edge where in_valid and in_ready are both high. in_valid and the token
// fields must stay stable until that edge. in_ready depends only on registered
// state (buffer occupancy and the post-reset enable), never on in_valid.
module timestamped_token_driver #(
   parameter int DATA_WIDTH = 1,
   parameter int TIME_WIDTH = 32,
   parameter int INIT_VALUE = 0,
   parameter int DEPTH      = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         advance,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [TIME_WIDTH-1:0]        in_time,
   input  logic [DATA_WIDTH-1:0]        in_data,
   output logic [DATA_WIDTH-1:0]        q,
   output logic [TIME_WIDTH-1:0]        now,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         empty,
   output logic                         late_err
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [DATA_WIDTH-1:0] INIT_Q = DATA_WIDTH'(INIT_VALUE);
   localparam logic [CNT_W-1:0]      FULL_COUNT = CNT_W'(DEPTH);

   // Token storage
   logic [TIME_WIDTH-1:0] mem_time_q [DEPTH];
   logic [TIME_WIDTH-1:0] mem_time_d [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_q [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data_d [DEPTH];

   // Pointers, occupancy and time base
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]      count_q, count_d;
   logic [TIME_WIDTH-1:0] now_q, now_d;

   // Driven signal and status
   logic [DATA_WIDTH-1:0] q_q, q_d;
   logic                  late_q, late_d;
   logic                  ready_en_q, ready_en_d;

   // Combinational decode of the head token
   logic [TIME_WIDTH-1:0] head_time;
   logic [DATA_WIDTH-1:0] head_data;
   logic [TIME_WIDTH-1:0] diff;
   logic                  buf_empty;
   logic                  buf_full;
   logic                  head_due;
   logic                  head_late;
   logic                  fire;
   logic                  push;

   // Head inspection and fire decision, all from registered state
   always_comb begin
      head_time = mem_time_q[rd_ptr_q];
      head_data = mem_data_q[rd_ptr_q];
      // Modular difference: MSB set means the stamp is behind local time.
      diff      = head_time - now_q;
      buf_empty = (count_q == '0);
      buf_full  = (count_q == FULL_COUNT);
      head_late = diff[TIME_WIDTH-1];
      head_due  = (diff == '0) || head_late;
      fire      = !buf_empty && head_due;
      // A full buffer refuses a push even when a pop happens this cycle.
      in_ready  = ready_en_q && !buf_full;
      push      = in_valid && in_ready;
   end

   // Next-state for buffer, pointers, time and outputs
   always_comb begin
      mem_time_d = mem_time_q;
      mem_data_d = mem_data_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      now_d      = now_q;
      q_d        = q_q;
      late_d     = late_q;
      ready_en_d = 1'b1;

      if (push) begin
         mem_time_d[wr_ptr_q] = in_time;
         mem_data_d[wr_ptr_q] = in_data;
         wr_ptr_d             = wr_ptr_q + PTR_W'(1);
      end

      if (fire) begin
         q_d      = head_data;
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         if (head_late) begin
            late_d = 1'b1;
         end
      end

      case ({push, fire})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (advance) begin
         now_d = now_q + TIME_WIDTH'(1);
      end
   end

   // State registers with asynchronous active-low clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_time_q[i] <= '0;
            mem_data_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         now_q      <= '0;
         q_q        <= INIT_Q;
         late_q     <= 1'b0;
         ready_en_q <= 1'b0;
      end else begin
         mem_time_q <= mem_time_d;
         mem_data_q <= mem_data_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         now_q      <= now_d;
         q_q        <= q_d;
         late_q     <= late_d;
         ready_en_q <= ready_en_d;
      end
   end

   // Output mapping
   always_comb begin
      q        = q_q;
      now      = now_q;
      count    = count_q;
      empty    = (count_q == '0);
      late_err = late_q;
   end

endmodule

// File: tb/tb_timestamped_token_driver.sv
// Directed bench for timestamped_token_driver (DATA_WIDTH=1, TIME_WIDTH=8,
// DEPTH=4, INIT_VALUE=0). Inputs change 1 time unit after each rising edge;
// outputs are checked at that same point, away from the edge.
module tb_timestamped_token_driver;

   logic       clk;
   logic       rst_n;
   logic       advance;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_time;
   logic [0:0] in_data;
   logic [0:0] q;
   logic [7:0] now;
   logic [2:0] count;
   logic       empty;
   logic       late_err;

   int checks;
   int failures;

   timestamped_token_driver #(
      .DATA_WIDTH (1),
      .TIME_WIDTH (8),
      .INIT_VALUE (0),
      .DEPTH      (4)
   ) dut (
      .clock    (clk),
      .reset    (rst_n),
      .advance  (advance),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_time  (in_time),
      .in_data  (in_data),
      .q        (q),
      .now      (now),
      .count    (count),
      .empty    (empty),
      .late_err (late_err)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // one clock edge, then settle
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // assert reset between edges, hold it across two edges, release between edges
   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      advance  = 1'b0;
      in_time  = '0;
      in_data  = '0;
      steps(2);
      rst_n = 1'b1;
   endtask

   task automatic drive(input logic v, input logic [7:0] t, input logic d);
      in_valid = v;
      in_time  = t;
      in_data  = d;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      advance  = 1'b0;
      in_valid = 1'b0;
      in_time  = '0;
      in_data  = '0;
      #2;
      // reset values
      chk("rst_q", 32'(q), 32'd0);
      chk("rst_now", 32'(now), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_late", 32'(late_err), 32'd0);
      chk("rst_ready", 32'(in_ready), 32'd0);

      // ---- 1: advancing time, two tokens on time
      do_reset();
      advance = 1'b1;
      #1;
      chk("t1_ready_before_edge", 32'(in_ready), 32'd0);
      step();
      chk("t1_ready_after_edge", 32'(in_ready), 32'd1);
      chk("t1_now1", 32'(now), 32'd1);
      drive(1'b1, 8'd3, 1'b1);
      step();                      // pre-edge now=1, accept (3,1)
      chk("t1_count1", 32'(count), 32'd1);
      drive(1'b1, 8'd5, 1'b0);
      step();                      // pre-edge now=2, accept (5,0)
      chk("t1_count2", 32'(count), 32'd2);
      chk("t1_q_before", 32'(q), 32'd0);
      drive(1'b0, 8'd0, 1'b0);
      step();                      // pre-edge now=3 -> fire
      chk("t1_q_at3", 32'(q), 32'd1);
      chk("t1_now_at3", 32'(now), 32'd4);
      chk("t1_count_at3", 32'(count), 32'd1);
      step();                      // pre-edge now=4 -> hold
      chk("t1_q_hold", 32'(q), 32'd1);
      step();                      // pre-edge now=5 -> fire
      chk("t1_q_at5", 32'(q), 32'd0);
      chk("t1_empty", 32'(empty), 32'd1);
      chk("t1_late", 32'(late_err), 32'd0);

      // ---- 2: held time, then a late token
      do_reset();
      steps(2);
      chk("t2_now_held", 32'(now), 32'd0);
      chk("t2_late_clear", 32'(late_err), 32'd0);
      advance = 1'b1;
      steps(10);
      advance = 1'b0;
      chk("t2_now10", 32'(now), 32'd10);
      drive(1'b1, 8'd4, 1'b1);
      step();
      chk("t2_count", 32'(count), 32'd1);
      chk("t2_q_pre", 32'(q), 32'd0);
      drive(1'b0, 8'd0, 1'b0);
      step();
      chk("t2_q_late", 32'(q), 32'd1);
      chk("t2_late_set", 32'(late_err), 32'd1);
      chk("t2_empty", 32'(empty), 32'd1);
      steps(3);
      chk("t2_late_sticky", 32'(late_err), 32'd1);
      chk("t2_now_still10", 32'(now), 32'd10);

      // ---- 3: fill the buffer with future stamps
      do_reset();
      step();                      // in_ready comes up
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 8'(100 + i), 1'(i % 2 == 0));
         step();
      end
      chk("t3_count_full", 32'(count), 32'd4);
      chk("t3_ready_low", 32'(in_ready), 32'd0);
      chk("t3_q_unchanged", 32'(q), 32'd0);
      chk("t3_not_empty", 32'(empty), 32'd0);
      drive(1'b0, 8'd0, 1'b0);

      // ---- 5: full buffer whose first two heads are due at now=5
      do_reset();
      step();
      drive(1'b1, 8'd5, 1'b1); step();
      drive(1'b1, 8'd5, 1'b0); step();
      drive(1'b1, 8'd9, 1'b1); step();
      drive(1'b1, 8'd9, 1'b0); step();
      drive(1'b0, 8'd0, 1'b0);
      chk("t5_full", 32'(count), 32'd4);
      advance = 1'b1;
      steps(5);
      advance = 1'b0;
      chk("t5_now5", 32'(now), 32'd5);
      chk("t5_q_not_yet", 32'(q), 32'd0);
      drive(1'b1, 8'd20, 1'b1);
      step();                      // pop (5,1) only, push blocked
      chk("t5_count3", 32'(count), 32'd3);
      chk("t5_q_a", 32'(q), 32'd1);
      chk("t5_ready_up", 32'(in_ready), 32'd1);
      step();                      // pop (5,0) and push (20,1)
      chk("t5_count_still3", 32'(count), 32'd3);
      chk("t5_q_b", 32'(q), 32'd0);
      drive(1'b0, 8'd0, 1'b0);
      step();                      // head (9,1) not due at now=5
      chk("t5_count_hold", 32'(count), 32'd3);
      chk("t5_q_hold", 32'(q), 32'd0);
      chk("t5_late", 32'(late_err), 32'd0);

      // ---- 4: wrap of the 8-bit time counter
      do_reset();
      advance = 1'b1;
      steps(250);
      chk("t4_now250", 32'(now), 32'd250);
      drive(1'b1, 8'd2, 1'b1);
      step();                      // accepted at pre-edge now=250
      drive(1'b0, 8'd0, 1'b0);
      chk("t4_count", 32'(count), 32'd1);
      for (int i = 0; i < 7; i++) begin
         chk("t4_no_early_fire", 32'(q), 32'd0);
         step();
      end
      chk("t4_now_wrapped", 32'(now), 32'd2);
      chk("t4_q_pre", 32'(q), 32'd0);
      step();                      // pre-edge now=2 -> fire
      chk("t4_q_fire", 32'(q), 32'd1);
      chk("t4_late", 32'(late_err), 32'd0);
      chk("t4_empty", 32'(empty), 32'd1);

      // ---- 6: reset with tokens in flight
      do_reset();
      advance = 1'b1;
      step();
      drive(1'b1, 8'd3, 1'b1);  step();
      drive(1'b1, 8'd50, 1'b1); step();
      drive(1'b1, 8'd60, 1'b1); step();
      drive(1'b1, 8'd70, 1'b1); step();
      drive(1'b0, 8'd0, 1'b0);
      chk("t6_count3", 32'(count), 32'd3);
      chk("t6_q1", 32'(q), 32'd1);
      chk("t6_now5", 32'(now), 32'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_q", 32'(q), 32'd0);
      chk("t6_async_now", 32'(now), 32'd0);
      chk("t6_async_count", 32'(count), 32'd0);
      chk("t6_async_empty", 32'(empty), 32'd1);
      chk("t6_async_ready", 32'(in_ready), 32'd0);
      step();
      rst_n   = 1'b1;
      advance = 1'b1;
      for (int i = 0; i < 80; i++) begin
         step();
         chk("t6_no_stale_token", 32'({count, q}), 32'd0);
      end
      chk("t6_now80", 32'(now), 32'd80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // global time limit
   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
